// File: rtl/video_pkg.sv
// Shared types and constants for the video memory fetch path.
package video_pkg;

  localparam int VRAM_AW     = 14;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VRD  = 2'd1,
    CWR  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/vram_fetch_if.sv
// Video, CPU and memory-side signals of the VRAM fetch arbiter.
interface vram_fetch_if
  import video_pkg::*;
#(
  parameter int AW = VRAM_AW
);

  logic [AW-1:0] vid_addr;
  logic [15:0]   vid_data;

  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_din;
  logic [1:0]    cpu_wtbt;
  logic          cpu_ack;

  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [1:0]    mem_be;
  logic [15:0]   mem_dout;
  logic [15:0]   mem_din;
  logic          mem_ack;

  logic          err;

  // master: the fetch/arbiter block; slave: the video stage, CPU and memory around it
  modport master (
    input  vid_addr, cpu_req, cpu_addr, cpu_din, cpu_wtbt, mem_din, mem_ack,
    output vid_data, cpu_ack, mem_addr, mem_rd, mem_wr, mem_be, mem_dout, err
  );

  modport slave (
    output vid_addr, cpu_req, cpu_addr, cpu_din, cpu_wtbt, mem_din, mem_ack,
    input  vid_data, cpu_ack, mem_addr, mem_rd, mem_wr, mem_be, mem_dout, err
  );

endinterface

// File: rtl/byte_merge.sv
// Per-byte merge of a new 16-bit word into an old one under a 2-bit byte enable.
module byte_merge (
  input  logic [15:0] old_data,
  input  logic [15:0] new_data,
  input  logic [1:0]  be,
  output logic [15:0] merged
);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_byte
      assign merged[gi*8 +: 8] = be[gi] ? new_data[gi*8 +: 8] : old_data[gi*8 +: 8];
    end
  endgenerate

endmodule

// File: rtl/vram_fetch.sv
// Arbitrates one single-port VRAM between video reads (priority) and CPU writes,
// holding the last fetched video word and keeping it coherent with CPU writes.
module vram_fetch
  import video_pkg::*;
#(
  parameter int AW      = VRAM_AW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic          clk_sys,
  input logic          reset,
  vram_fetch_if.master bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  fetch_state_t  state_reg;
  logic          pend_vid_reg;
  logic [AW-1:0] req_addr_reg;
  logic [AW-1:0] fetched_addr_reg;
  logic [TW-1:0] timer_reg;
  logic          cpu_arm_reg;
  logic          cpu_pend_reg;

  logic [15:0]   vid_data_reg;
  logic [AW-1:0] mem_addr_reg;
  logic          mem_rd_reg;
  logic          mem_wr_reg;
  logic [1:0]    mem_be_reg;
  logic [15:0]   mem_dout_reg;
  logic          cpu_ack_reg;
  logic          err_reg;

  logic          vid_changed;
  logic [AW-1:0] rd_addr_next;
  logic          expired;
  logic [15:0]   merged;

  assign vid_changed  = (bus.vid_addr != fetched_addr_reg) && (state_reg != VRD);
  // A change seen this very cycle is newer than the latched request address
  assign rd_addr_next = vid_changed ? bus.vid_addr : req_addr_reg;
  assign expired      = (timer_reg == TW'(TIMEOUT - 1));

  byte_merge u_merge (
    .old_data (vid_data_reg),
    .new_data (mem_dout_reg),
    .be       (mem_be_reg),
    .merged   (merged)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      pend_vid_reg     <= 1'b1;
      req_addr_reg     <= '1;
      fetched_addr_reg <= '1;
      timer_reg        <= '0;
      cpu_arm_reg      <= 1'b1;
      cpu_pend_reg     <= 1'b0;
      vid_data_reg     <= '0;
      mem_addr_reg     <= '0;
      mem_rd_reg       <= 1'b0;
      mem_wr_reg       <= 1'b0;
      mem_be_reg       <= '0;
      mem_dout_reg     <= '0;
      cpu_ack_reg      <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      cpu_ack_reg <= 1'b0;

      if (vid_changed) begin
        pend_vid_reg <= 1'b1;
        req_addr_reg <= bus.vid_addr;
      end

      // One accepted request per rising level of cpu_req
      if (!bus.cpu_req) begin
        cpu_arm_reg  <= 1'b1;
        cpu_pend_reg <= 1'b0;
      end else if (cpu_arm_reg) begin
        cpu_arm_reg  <= 1'b0;
        cpu_pend_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          timer_reg <= '0;
          if (pend_vid_reg) begin
            state_reg    <= VRD;
            mem_addr_reg <= rd_addr_next;
            mem_rd_reg   <= 1'b1;
          end else if (cpu_pend_reg && bus.cpu_req && !cpu_ack_reg) begin
            cpu_pend_reg <= 1'b0;
            if (bus.cpu_wtbt == 2'b00) begin
              cpu_ack_reg <= 1'b1;
            end else begin
              state_reg    <= CWR;
              mem_addr_reg <= bus.cpu_addr;
              mem_dout_reg <= bus.cpu_din;
              mem_be_reg   <= bus.cpu_wtbt;
              mem_wr_reg   <= 1'b1;
            end
          end
        end

        VRD: begin
          if (bus.mem_ack) begin
            vid_data_reg     <= bus.mem_din;
            fetched_addr_reg <= mem_addr_reg;
            pend_vid_reg     <= 1'b0;
            mem_rd_reg       <= 1'b0;
            state_reg        <= IDLE;
          end else if (expired) begin
            // pend_vid stays set so the read is retried from IDLE
            mem_rd_reg <= 1'b0;
            err_reg    <= 1'b1;
            state_reg  <= IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        CWR: begin
          if (bus.mem_ack) begin
            mem_wr_reg  <= 1'b0;
            cpu_ack_reg <= 1'b1;
            state_reg   <= IDLE;
            if (mem_addr_reg == fetched_addr_reg) begin
              vid_data_reg <= merged;
            end
          end else if (expired) begin
            mem_wr_reg  <= 1'b0;
            cpu_ack_reg <= 1'b1;
            err_reg     <= 1'b1;
            state_reg   <= IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        default: begin
          state_reg  <= IDLE;
          mem_rd_reg <= 1'b0;
          mem_wr_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vid_data = vid_data_reg;
  assign bus.mem_addr = mem_addr_reg;
  assign bus.mem_rd   = mem_rd_reg;
  assign bus.mem_wr   = mem_wr_reg;
  assign bus.mem_be   = mem_be_reg;
  assign bus.mem_dout = mem_dout_reg;
  assign bus.cpu_ack  = cpu_ack_reg;
  assign bus.err      = err_reg;

endmodule

// File: tb/tb_vram_fetch.sv
// Directed bench for vram_fetch: reset, fetch, priority, coherency, re-read, timeouts, async reset.
module tb_vram_fetch;
  import video_pkg::*;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   total   = 0;
  int   bad     = 0;

  vram_fetch_if #(.AW(VRAM_AW)) bus ();

  vram_fetch #(.AW(VRAM_AW), .TIMEOUT(DEF_TIMEOUT)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  // Advance to the next falling edge; mem_ack is a one-cycle pulse
  task automatic tick();
    @(negedge clk_sys);
    bus.mem_ack = 1'b0;
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.mem_rd || bus.mem_wr) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.vid_addr = 14'h0123;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_din  = '0;
    bus.cpu_wtbt = 2'b00;
    bus.mem_din  = '0;
    bus.mem_ack  = 1'b0;
    repeat (2) @(negedge clk_sys);
    total++; if (bus.vid_data !== 16'h0000) begin bad++; $display("FAIL reset_vid_data: got %h want 0000", bus.vid_data); end
    total++; if ({bus.mem_rd, bus.mem_wr, bus.cpu_ack, bus.err} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {bus.mem_rd, bus.mem_wr, bus.cpu_ack, bus.err}); end
    total++; if (bus.mem_addr !== 14'h0000) begin bad++; $display("FAIL reset_mem_addr: got %h want 0000", bus.mem_addr); end
    total++; if (bus.mem_be !== 2'b00) begin bad++; $display("FAIL reset_mem_be: got %b want 00", bus.mem_be); end
    total++; if (bus.mem_dout !== 16'h0000) begin bad++; $display("FAIL reset_mem_dout: got %h want 0000", bus.mem_dout); end
    reset = 1'b0;
    $display("reset released, vid_addr=0123");
  endtask

  task automatic test_first_fetch();
    bit ok;
    int hi;
    wait_strobe(ok);
    total++; if (!ok || bus.mem_rd !== 1'b1) begin bad++; $display("FAIL fetch_start: got rd=%b want rd=1", bus.mem_rd); end
    total++; if (bus.mem_addr !== 14'h0123) begin bad++; $display("FAIL fetch_addr: got %h want 0123", bus.mem_addr); end
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.mem_rd) break;
      hi++;
      if (hi == 4) begin bus.mem_ack = 1'b1; bus.mem_din = 16'hA5C3; end
      tick();
    end
    total++; if (hi != 4) begin bad++; $display("FAIL fetch_rd_len: got %0d want 4", hi); end
    total++; if (bus.vid_data !== 16'hA5C3) begin bad++; $display("FAIL fetch_data: got %h want a5c3", bus.vid_data); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL fetch_err: got %b want 0", bus.err); end
    $display("read 0123 -> %h", bus.vid_data);
  endtask

  task automatic test_priority();
    bit ok;
    int acks;
    bus.vid_addr = 14'h0040;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 14'h0200;
    bus.cpu_din  = 16'h1234;
    bus.cpu_wtbt = 2'b11;
    wait_strobe(ok);
    total++; if (!ok || {bus.mem_rd, bus.mem_wr} !== 2'b10) begin bad++; $display("FAIL prio_read_first: got rd/wr=%b want 10", {bus.mem_rd, bus.mem_wr}); end
    total++; if (bus.mem_addr !== 14'h0040) begin bad++; $display("FAIL prio_read_addr: got %h want 0040", bus.mem_addr); end
    bus.mem_ack = 1'b1; bus.mem_din = 16'hBEEF;
    tick();
    total++; if ({bus.mem_rd, bus.mem_wr} !== 2'b00) begin bad++; $display("FAIL prio_idle_gap: got rd/wr=%b want 00", {bus.mem_rd, bus.mem_wr}); end
    tick();
    total++; if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 14'h0200 || bus.mem_dout !== 16'h1234 || bus.mem_be !== 2'b11) begin
      bad++; $display("FAIL prio_write: got wr=%b addr=%h dout=%h be=%b want 1 0200 1234 11", bus.mem_wr, bus.mem_addr, bus.mem_dout, bus.mem_be);
    end
    bus.mem_ack = 1'b1;
    tick();
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.cpu_ack) acks++;
      bus.cpu_req = 1'b0;
      tick();
    end
    total++; if (acks != 1) begin bad++; $display("FAIL prio_ack_count: got %0d want 1", acks); end
    total++; if (bus.vid_data !== 16'hBEEF) begin bad++; $display("FAIL prio_vid_data: got %h want beef", bus.vid_data); end
    $display("read 0040 -> %h, write 0200 <= 1234", bus.vid_data);
  endtask

  task automatic test_coherency();
    bit ok;
    int rds;
    bus.vid_addr = 14'h0123;
    wait_strobe(ok);
    bus.mem_ack = 1'b1; bus.mem_din = 16'hA5C3;
    tick();
    total++; if (!ok || bus.vid_data !== 16'hA5C3) begin bad++; $display("FAIL coh_setup: got %h want a5c3", bus.vid_data); end
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 14'h0123;
    bus.cpu_din  = 16'h7F00;
    bus.cpu_wtbt = 2'b10;
    wait_strobe(ok);
    total++; if (!ok || bus.mem_wr !== 1'b1 || bus.mem_be !== 2'b10 || bus.mem_addr !== 14'h0123) begin
      bad++; $display("FAIL coh_write: got wr=%b be=%b addr=%h want 1 10 0123", bus.mem_wr, bus.mem_be, bus.mem_addr);
    end
    bus.mem_ack = 1'b1;
    tick();
    total++; if (bus.cpu_ack !== 1'b1 || bus.vid_data !== 16'h7FC3) begin
      bad++; $display("FAIL coh_merge: got ack=%b vid=%h want 1 7fc3", bus.cpu_ack, bus.vid_data);
    end
    bus.cpu_req = 1'b0;
    rds = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.mem_rd) rds++;
    end
    total++; if (rds != 0) begin bad++; $display("FAIL coh_no_reread: got %0d read cycles want 0", rds); end
    $display("write 0123 <= 7f00 be=10, vid_data=%h", bus.vid_data);
  endtask

  task automatic test_stale_reread();
    bit ok;
    int gap;
    bus.vid_addr = 14'h0010;
    wait_strobe(ok);
    total++; if (!ok || bus.mem_addr !== 14'h0010) begin bad++; $display("FAIL stale_first_addr: got %h want 0010", bus.mem_addr); end
    tick();
    bus.vid_addr = 14'h0011;
    tick();
    bus.mem_ack = 1'b1; bus.mem_din = 16'h1111;
    tick();
    total++; if (bus.vid_data !== 16'h1111 || bus.mem_rd !== 1'b0) begin bad++; $display("FAIL stale_data: got vid=%h rd=%b want 1111 0", bus.vid_data, bus.mem_rd); end
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_rd) break;
      gap++;
      tick();
    end
    total++; if (gap != 2 || bus.mem_addr !== 14'h0011) begin bad++; $display("FAIL stale_reread: got gap=%0d addr=%h want 2 0011", gap, bus.mem_addr); end
    total++; if (bus.vid_data !== 16'h1111) begin bad++; $display("FAIL stale_held: got %h want 1111", bus.vid_data); end
    bus.mem_ack = 1'b1; bus.mem_din = 16'h2222;
    tick();
    total++; if (bus.vid_data !== 16'h2222) begin bad++; $display("FAIL stale_second: got %h want 2222", bus.vid_data); end
    $display("read 0010 -> 1111, re-read 0011 -> %h", bus.vid_data);
  endtask

  task automatic test_timeout();
    bit ok;
    int hi;
    bus.vid_addr = 14'h0300;
    wait_strobe(ok);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.mem_rd) break;
      hi++;
      tick();
    end
    total++; if (!ok || hi != 15) begin bad++; $display("FAIL to_rd_len: got %0d want 15", hi); end
    total++; if (bus.err !== 1'b1 || bus.vid_data !== 16'h2222) begin bad++; $display("FAIL to_rd_err: got err=%b vid=%h want 1 2222", bus.err, bus.vid_data); end
    tick();
    total++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 14'h0300) begin bad++; $display("FAIL to_retry: got rd=%b addr=%h want 1 0300", bus.mem_rd, bus.mem_addr); end
    bus.mem_ack = 1'b1; bus.mem_din = 16'h3333;
    tick();
    total++; if (bus.vid_data !== 16'h3333) begin bad++; $display("FAIL to_retry_data: got %h want 3333", bus.vid_data); end
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 14'h0500;
    bus.cpu_din  = 16'h5555;
    bus.cpu_wtbt = 2'b11;
    wait_strobe(ok);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.mem_wr) break;
      hi++;
      tick();
    end
    total++; if (!ok || hi != 15 || bus.cpu_ack !== 1'b1) begin bad++; $display("FAIL to_wr: got len=%0d ack=%b want 15 1", hi, bus.cpu_ack); end
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL to_err_sticky: got %b want 1", bus.err); end
    bus.cpu_req = 1'b0;
    tick();
    $display("read 0300 timed out then -> 3333, write 0500 timed out");
  endtask

  task automatic test_zero_enable();
    int acks;
    int strobes;
    bus.mem_ack = 1'b1; bus.mem_din = 16'hDEAD;
    tick();
    total++; if (bus.vid_data !== 16'h3333) begin bad++; $display("FAIL stray_ack: got %h want 3333", bus.vid_data); end
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 14'h0300;
    bus.cpu_din  = 16'hFFFF;
    bus.cpu_wtbt = 2'b00;
    acks = 0; strobes = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.cpu_ack) begin acks++; bus.cpu_req = 1'b0; end
      if (bus.mem_rd || bus.mem_wr) strobes++;
    end
    bus.cpu_req = 1'b0;
    total++; if (acks != 1 || strobes != 0 || bus.vid_data !== 16'h3333) begin
      bad++; $display("FAIL zero_be: got acks=%0d strobes=%0d vid=%h want 1 0 3333", acks, strobes, bus.vid_data);
    end
    $display("write 0300 with be=00 acked without memory cycle");
  endtask

  task automatic test_reset_mid();
    bit ok;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 14'h0600;
    bus.cpu_din  = 16'h6666;
    bus.cpu_wtbt = 2'b11;
    wait_strobe(ok);
    total++; if (!ok || bus.mem_wr !== 1'b1) begin bad++; $display("FAIL rst_mid_setup: got wr=%b want 1", bus.mem_wr); end
    bus.vid_addr = 14'h0700;
    tick();
    #2 reset = 1'b1;
    #1;
    total++; if (bus.mem_wr !== 1'b0 || bus.cpu_ack !== 1'b0 || bus.err !== 1'b0) begin
      bad++; $display("FAIL rst_async: got wr=%b ack=%b err=%b want 0 0 0", bus.mem_wr, bus.cpu_ack, bus.err);
    end
    @(negedge clk_sys);
    reset = 1'b0;
    wait_strobe(ok);
    total++; if (!ok || {bus.mem_rd, bus.mem_wr} !== 2'b10 || bus.mem_addr !== 14'h0700) begin
      bad++; $display("FAIL rst_read_first: got rd/wr=%b addr=%h want 10 0700", {bus.mem_rd, bus.mem_wr}, bus.mem_addr);
    end
    bus.mem_ack = 1'b1; bus.mem_din = 16'h7777;
    tick();
    wait_strobe(ok);
    total++; if (!ok || bus.mem_wr !== 1'b1 || bus.mem_addr !== 14'h0600) begin
      bad++; $display("FAIL rst_write_after: got wr=%b addr=%h want 1 0600", bus.mem_wr, bus.mem_addr);
    end
    bus.mem_ack = 1'b1;
    tick();
    bus.cpu_req = 1'b0;
    tick();
    $display("reset during write 0600; read 0700 -> %h then write reissued", bus.vid_data);
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_priority();
    test_coherency();
    test_stale_reread();
    test_timeout();
    test_zero_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_fetch.md
Name: vram_fetch

Overview:
- Sits directly upstream of the video timing/pixel stage. Supplies the 16-bit VRAM word that the video stage requests with `vram_addr`.
- Arbitrates one shared single-port VRAM/SDRAM-style memory interface between video fetches (high priority) and CPU writes (low priority).
- Holds the last fetched word stable so the video stage can sample it at any point of a 16-pixel group. A video group lasts 16 ce_12mp ticks.
- Keeps the held word coherent with CPU writes to the same address.

Parameters:
- AW, 14, word address width; matches `vram_addr`.
- TIMEOUT, 15, max clk_sys cycles to wait for mem_ack before a transaction is abandoned.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- vid_addr  in  AW  word address from video stage ({bank, row, column})
- vid_data  out  16  last fetched video word, held stable
- cpu_req  in  1  CPU write request, level; held until cpu_ack
- cpu_addr  in  AW  CPU word address
- cpu_din  in  16  CPU write data
- cpu_wtbt  in  2  byte enables {hi, lo}; 2'b11 = word
- cpu_ack  out  1  one-cycle pulse, write retired
- mem_addr  out  AW  memory address
- mem_rd  out  1  read strobe, held until mem_ack or timeout
- mem_wr  out  1  write strobe, held until mem_ack or timeout
- mem_be  out  2  byte enables for writes
- mem_dout  out  16  write data to memory
- mem_din  in  16  read data, valid in the mem_ack cycle
- mem_ack  in  1  one-cycle completion pulse
- err  out  1  sticky; set on any timeout

Behaviour:
- Reset values:
  - Outputs: vid_data=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_be=0, mem_dout=0, cpu_ack=0, err=0.
  - Internal: fetched_addr=all-ones, pend_vid=1, state=IDLE.
- Change detection: every cycle, if vid_addr != fetched_addr and the FSM is not in VRD, set pend_vid=1 and latch req_addr=vid_addr.
- FSM states:
  - IDLE:
    - If pend_vid: go to VRD; mem_addr=req_addr, mem_rd=1.
    - Else if cpu_req and not cpu_ack: go to CWR; mem_addr=cpu_addr, mem_dout=cpu_din, mem_be=cpu_wtbt, mem_wr=1.
    - A write with cpu_wtbt=0 acks immediately without a memory cycle.
  - VRD on mem_ack:
    - vid_data<=mem_din, fetched_addr<=req_addr, pend_vid<=0, mem_rd<=0; go to IDLE.
    - If vid_addr changed during the read, pend_vid is re-raised the next cycle and a new read follows. The stale data is still presented in the meantime.
  - CWR on mem_ack:
    - mem_wr<=0, cpu_ack<=1 (one cycle); go to IDLE.
    - If mem_addr==fetched_addr, merge cpu_din into vid_data per byte enable in the same cycle. This is the coherency rule.
- Priority: video wins when both are pending in IDLE. A CPU write in progress is never pre-empted. Worst-case video latency = one CPU write + one read.
- Timeout: a counter of TIMEOUT cycles runs in VRD/CWR.
  - On expiry: drop the strobe, set err=1, go to IDLE.
  - VRD expiry: vid_data unchanged; pend_vid stays 1, so the read retries.
  - CWR expiry: pulse cpu_ack anyway so the CPU does not hang.
- Back-to-back: at least one IDLE cycle between transactions; strobes are deasserted for at least one cycle.
- cpu_ack: the next request is accepted only after cpu_req has been observed low or a new cycle starts. One ack is issued per request edge; an edge detector is kept on cpu_req.
- Reset mid-transaction: strobes drop immediately (asynchronously); all state returns to reset values; an outstanding ack is lost.
- mem_ack outside VRD/CWR is ignored.

Decomposition:
- Shared package video_pkg holds:
  - State enum {IDLE, VRD, CWR}.
  - VRAM_AW=14.
  - Default TIMEOUT.
- One sub-module, byte_merge: 16-bit old/new data plus 2-bit enable, producing the merged word. It is combinational and reused by CWR coherency and by future palette/cache logic.

Test Plan:
- Reset, then vid_addr=14'h0123; memory acks after 3 cycles with 16'hA5C3 -> mem_rd high exactly 4 cycles, vid_data=16'hA5C3 the cycle after ack, err=0.
- vid_addr and cpu_req rise in the same cycle (cpu_addr=14'h0200, din=16'h1234, wtbt=11) -> read issued first; write follows after one IDLE cycle; single cpu_ack pulse.
- With fetched_addr=14'h0123 and vid_data=16'hA5C3, CPU writes 16'h7F00 with wtbt=2'b10 to 14'h0123 -> mem_be=10, vid_data becomes 16'h7FC3 on ack, no re-read.
- vid_addr changes from 14'h0010 to 14'h0011 during an outstanding read -> first ack loads vid_data with the 0x0010 data; a second read for 0x0011 starts 2 cycles later.
- No mem_ack for a read -> mem_rd drops after 15 cycles, err=1, retry read issued; CPU write with no ack -> cpu_ack pulses after timeout.
- Assert reset mid-CWR -> mem_wr=0 in the same cycle (async); after release, a read of the current vid_addr is issued first (pend_vid=1).
